// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and helpers for the RC4 engines.
//   ksa_state_e       : key-scheduling FSM state encoding
//   KSA_MAX_KEY_BYTES : largest supported key length in words
//   KSA_MAX_WORD_W    : largest supported S-memory word width
//   key_word()        : extracts word k of a flattened key (word 0 = MSB word)
// -----------------------------------------------------------------------------
package rc4_pkg;

   localparam int KSA_MAX_KEY_BYTES = 16;
   localparam int KSA_MAX_WORD_W    = 16;
   localparam int KSA_MAX_KEY_W     = KSA_MAX_KEY_BYTES * KSA_MAX_WORD_W;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_INIT   = 4'd1,
      S_RD_I   = 4'd2,
      S_WAIT_I = 4'd3,
      S_CALC_J = 4'd4,
      S_RD_J   = 4'd5,
      S_WAIT_J = 4'd6,
      S_WR_I   = 4'd7,
      S_WR_J   = 4'd8,
      S_DONE   = 4'd9
   } ksa_state_e;

   // The key is zero-extended to the widest supported size so one function
   // serves every parameterisation; the caller truncates the result.
   function automatic logic [KSA_MAX_KEY_W-1:0] key_word(
      input logic [KSA_MAX_KEY_W-1:0] key,
      input int unsigned              key_bytes,
      input int unsigned              word_w,
      input int unsigned              k
   );
      logic [KSA_MAX_KEY_W-1:0] mask;
      mask = (KSA_MAX_KEY_W'(1'b1) << word_w) - KSA_MAX_KEY_W'(1'b1);
      return (key >> ((key_bytes - 32'd1 - k) * word_w)) & mask;
   endfunction

endpackage

// File: rtl/rc4_wait_ctr.sv
// -----------------------------------------------------------------------------
// rc4_wait_ctr
// Read-latency down-counter. Pulse load in the cycle that issues a memory
// address; expire is high in the last of the LAT following cycles, which is
// the cycle in which the read data may be captured.
//   clk    : clock
//   reset  : synchronous active-low reset
//   load   : restart the count
//   expire : count has reached zero
// -----------------------------------------------------------------------------
module rc4_wait_ctr #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire
);

   localparam int CW = 2;

   logic [CW-1:0] cnt_r;

   // Down-counter: load LAT-1, decrement to zero and hold there.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         cnt_r <= CW'(LAT - 1);
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_r <= cnt_r - CW'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// rc4_ksa_engine
// RC4 key-scheduling engine driving one single-port S-memory:
//   for i = 0..N-1: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
// Parameters: ADDR_W (N = 2**ADDR_W), KEY_BYTES (1..16), RD_LAT (1..4).
// Ports:
//   clk, reset (sync, active-low)
//   start      : level request, sampled in IDLE only
//   secret_key : KEY_BYTES words, word 0 in the MSBs
//   busy, done : handshake status (registered)
//   mem_addr, mem_wdata, mem_wren : S-memory command (registered)
//   mem_q      : S-memory read data, valid RD_LAT cycles after mem_addr
// Build option: KSA_INIT_EN adds an INIT phase writing S[a] = a before the
// key schedule; without it the memory must be initialised externally.
// -----------------------------------------------------------------------------
module rc4_ksa_engine
   import rc4_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int KEY_BYTES = 3,
   parameter int RD_LAT    = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [KEY_BYTES*ADDR_W-1:0] secret_key,
   output logic                        busy,
   output logic                        done,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [ADDR_W-1:0]           mem_wdata,
   output logic                        mem_wren,
   input  logic [ADDR_W-1:0]           mem_q
);

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [ADDR_W-1:0] I_LAST = {ADDR_W{1'b1}};
   localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);

   ksa_state_e        state_r, state_nxt_s;
   logic [ADDR_W-1:0] i_r, i_nxt_s;
   logic [ADDR_W-1:0] j_r, j_nxt_s;
   logic [KW-1:0]     k_r, k_nxt_s;
   logic [ADDR_W-1:0] si_r, si_nxt_s;
   logic [ADDR_W-1:0] sj_r, sj_nxt_s;
   logic [ADDR_W-1:0] addr_nxt_s, wdata_nxt_s;
   logic              wren_nxt_s, busy_nxt_s, done_nxt_s;
   logic              wait_load_s, wait_expire_s;
   logic [ADDR_W-1:0] key_k_s;

   assign key_k_s = ADDR_W'(key_word(KSA_MAX_KEY_W'(secret_key), KEY_BYTES, ADDR_W, 32'(k_r)));

   rc4_wait_ctr #(
      .LAT (RD_LAT)
   ) u_wait_ctr (
      .clk    (clk),
      .reset  (reset),
      .load   (wait_load_s),
      .expire (wait_expire_s)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt_s = state_r;
      i_nxt_s     = i_r;
      j_nxt_s     = j_r;
      k_nxt_s     = k_r;
      si_nxt_s    = si_r;
      sj_nxt_s    = sj_r;
      addr_nxt_s  = mem_addr;
      wdata_nxt_s = mem_wdata;
      wren_nxt_s  = 1'b0;
      busy_nxt_s  = busy;
      done_nxt_s  = done;
      wait_load_s = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (start) begin
               i_nxt_s    = {ADDR_W{1'b0}};
               j_nxt_s    = {ADDR_W{1'b0}};
               k_nxt_s    = {KW{1'b0}};
               busy_nxt_s = 1'b1;
`ifdef KSA_INIT_EN
               state_nxt_s = S_INIT;
`else
               state_nxt_s = S_RD_I;
`endif
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
`ifdef KSA_INIT_EN
         // i doubles as the fill address; it wraps back to 0 for the schedule.
         S_INIT: begin
            addr_nxt_s  = i_r;
            wdata_nxt_s = i_r;
            wren_nxt_s  = 1'b1;
            i_nxt_s     = i_r + ADDR_W'(1'b1);
            if (i_r == I_LAST) begin
               state_nxt_s = S_RD_I;
            end else begin
               state_nxt_s = S_INIT;
            end
         end
`endif
         S_RD_I: begin
            addr_nxt_s  = i_r;
            wait_load_s = 1'b1;
            state_nxt_s = S_WAIT_I;
         end
         S_WAIT_I: begin
            if (wait_expire_s) begin
               si_nxt_s    = mem_q;
               state_nxt_s = S_CALC_J;
            end else begin
               state_nxt_s = S_WAIT_I;
            end
         end
         S_CALC_J: begin
            j_nxt_s     = j_r + si_r + key_k_s;
            state_nxt_s = S_RD_J;
         end
         S_RD_J: begin
            addr_nxt_s  = j_r;
            wait_load_s = 1'b1;
            state_nxt_s = S_WAIT_J;
         end
         S_WAIT_J: begin
            if (wait_expire_s) begin
               sj_nxt_s    = mem_q;
               state_nxt_s = S_WR_I;
            end else begin
               state_nxt_s = S_WAIT_J;
            end
         end
         S_WR_I: begin
            addr_nxt_s  = i_r;
            wdata_nxt_s = sj_r;
            wren_nxt_s  = 1'b1;
            state_nxt_s = S_WR_J;
         end
         // When i == j both writes carry the same value, so no special case.
         S_WR_J: begin
            addr_nxt_s  = j_r;
            wdata_nxt_s = si_r;
            wren_nxt_s  = 1'b1;
            if (k_r == K_LAST) begin
               k_nxt_s = {KW{1'b0}};
            end else begin
               k_nxt_s = k_r + KW'(1'b1);
            end
            if (i_r == I_LAST) begin
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               i_nxt_s     = i_r + ADDR_W'(1'b1);
               state_nxt_s = S_RD_I;
            end
         end
         // A new run requires start to drop first.
         S_DONE: begin
            if (!start) begin
               done_nxt_s  = 1'b0;
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: begin
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= S_IDLE;
         i_r       <= {ADDR_W{1'b0}};
         j_r       <= {ADDR_W{1'b0}};
         k_r       <= {KW{1'b0}};
         si_r      <= {ADDR_W{1'b0}};
         sj_r      <= {ADDR_W{1'b0}};
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {ADDR_W{1'b0}};
         mem_wren  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         i_r       <= i_nxt_s;
         j_r       <= j_nxt_s;
         k_r       <= k_nxt_s;
         si_r      <= si_nxt_s;
         sj_r      <= sj_nxt_s;
         mem_addr  <= addr_nxt_s;
         mem_wdata <= wdata_nxt_s;
         mem_wren  <= wren_nxt_s;
         busy      <= busy_nxt_s;
         done      <= done_nxt_s;
      end
   end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// tb_rc4_ksa_engine
// Two engines: "a" at default parameters (ADDR_W=8, KEY_BYTES=3, RD_LAT=2)
// and "b" small (ADDR_W=2, KEY_BYTES=1, RD_LAT=2). Each drives a behavioural
// single-port RAM whose read data appears RD_LAT cycles after the address.
// Results are compared with a software KSA over plain integer arrays.
// -----------------------------------------------------------------------------
module tb_rc4_ksa_engine;

   localparam int N_A       = 256;
   localparam int N_B       = 4;
   localparam int ITER      = 9;       // 5 + 2*RD_LAT
   localparam int RUN_LIMIT = 20000;
`ifdef KSA_INIT_EN
   localparam int INIT_A = 256;
   localparam int INIT_B = 4;
`else
   localparam int INIT_A = 0;
   localparam int INIT_B = 0;
`endif

   int checks   = 0;
   int failures = 0;

   logic        clk;
   logic        reset;
   logic        start_a, start_b;
   logic [23:0] key_a;
   logic [1:0]  key_b;
   logic        busy_a, done_a, wren_a;
   logic        busy_b, done_b, wren_b;
   logic [7:0]  addr_a, wdata_a, q_a;
   logic [1:0]  addr_b, wdata_b, q_b;

   rc4_ksa_engine dut_a (
      .clk        (clk),
      .reset      (reset),
      .start      (start_a),
      .secret_key (key_a),
      .busy       (busy_a),
      .done       (done_a),
      .mem_addr   (addr_a),
      .mem_wdata  (wdata_a),
      .mem_wren   (wren_a),
      .mem_q      (q_a)
   );

   rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1), .RD_LAT(2)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .start      (start_b),
      .secret_key (key_b),
      .busy       (busy_b),
      .done       (done_b),
      .mem_addr   (addr_b),
      .mem_wdata  (wdata_b),
      .mem_wren   (wren_b),
      .mem_q      (q_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural RAMs: preload image on request, else write on wren;
   // read path has one register stage so q lags the address by two cycles.
   logic [7:0] ram_a [N_A];
   logic [7:0] img_a [N_A];
   logic [7:0] pipe_a;
   logic       load_a;
   logic [1:0] ram_b [N_B];
   logic [1:0] img_b [N_B];
   logic [1:0] pipe_b;
   logic       load_b;

   always @(posedge clk) begin
      if (load_a) begin
         for (int a = 0; a < N_A; a++) ram_a[a] <= img_a[a];
      end else if (wren_a) begin
         ram_a[addr_a] <= wdata_a;
      end
      pipe_a <= ram_a[addr_a];
   end
   assign q_a = pipe_a;

   always @(posedge clk) begin
      if (load_b) begin
         for (int a = 0; a < N_B; a++) ram_b[a] <= img_b[a];
      end else if (wren_b) begin
         ram_b[addr_b] <= wdata_b;
      end
      pipe_b <= ram_b[addr_b];
   end
   assign q_b = pipe_b;

   // Reference model state
   int model_a [N_A];
   int model_b [N_B];
   int snap_b  [N_B];

   task automatic ref_ksa_a(input logic [23:0] key);
      int j, t;
      int kb [3];
      kb[0] = int'(key[23:16]);
      kb[1] = int'(key[15:8]);
      kb[2] = int'(key[7:0]);
      j = 0;
      for (int i = 0; i < N_A; i++) begin
         j = (j + model_a[i] + kb[i % 3]) % N_A;
         t = model_a[i]; model_a[i] = model_a[j]; model_a[j] = t;
      end
   endtask

   task automatic ref_ksa_b(input logic [1:0] key);
      int j, t;
      j = 0;
      for (int i = 0; i < N_B; i++) begin
         j = (j + model_b[i] + int'(key)) % N_B;
         t = model_b[i]; model_b[i] = model_b[j]; model_b[j] = t;
      end
   endtask

   // kind: 0 identity, 1 random, 2 all 8'hAA. With the INIT build the
   // engine overwrites memory with the identity before scheduling.
   task automatic preload_a(input int kind);
      for (int a = 0; a < N_A; a++) begin
         case (kind)
            0:       img_a[a] = 8'(a);
            1:       img_a[a] = 8'($urandom());
            default: img_a[a] = 8'hAA;
         endcase
         model_a[a] = (INIT_A != 0) ? a : int'(img_a[a]);
      end
      @(negedge clk); load_a = 1'b1;
      @(negedge clk); load_a = 1'b0;
   endtask

   task automatic preload_b_identity();
      for (int a = 0; a < N_B; a++) begin
         img_b[a]   = 2'(a);
         model_b[a] = a;
      end
      @(negedge clk); load_b = 1'b1;
      @(negedge clk); load_b = 1'b0;
   endtask

   function automatic int diff_a();
      int bad = 0;
      for (int a = 0; a < N_A; a++) if (ram_a[a] !== 8'(model_a[a])) bad++;
      return bad;
   endfunction

   // Raise start and watch every cycle until done, abort_at or the limit.
   task automatic run_a(input int abort_at, output int edges, output int wrens,
                        output int overlaps, output logic busy_first);
      edges = 0; wrens = 0; overlaps = 0; busy_first = 1'b0;
      start_a = 1'b1;
      while (edges < RUN_LIMIT) begin
         @(negedge clk);
         edges++;
         if (edges == 1) busy_first = busy_a;
         if (wren_a === 1'b1) wrens++;
         if (busy_a === 1'b1 && done_a === 1'b1) overlaps++;
         if (done_a === 1'b1 || edges == abort_at) break;
      end
   endtask

   task automatic run_b(input int snap_at, output int edges, output int wrens);
      logic snap_pend;
      edges = 0; wrens = 0; snap_pend = 1'b0;
      start_b = 1'b1;
      while (edges < RUN_LIMIT) begin
         @(negedge clk);
         edges++;
         if (snap_pend) begin
            for (int a = 0; a < N_B; a++) snap_b[a] = int'(ram_b[a]);
            snap_pend = 1'b0;
         end
         if (wren_b === 1'b1) begin
            wrens++;
            if (wrens == snap_at) snap_pend = 1'b1;
         end
         if (done_b === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, done_a, wren_a, addr_a, wdata_a} !== 19'd0) begin
         failures++;
         $display("FAIL reset_a: got busy=%b done=%b wren=%b addr=%h wdata=%h, expected all zero",
                  busy_a, done_a, wren_a, addr_a, wdata_a);
      end
      checks++;
      if ({busy_b, done_b, wren_b, addr_b, wdata_b} !== 7'd0) begin
         failures++;
         $display("FAIL reset_b: got busy=%b done=%b wren=%b addr=%h wdata=%h, expected all zero",
                  busy_b, done_b, wren_b, addr_b, wdata_b);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_small(input logic [1:0] key, input int exp_f0, input int exp_f1,
                             input int exp_f2, input int exp_f3, input int exp_s0,
                             input int exp_s1, input int exp_s2, input int exp_s3);
      int edges, wrens;
      int exp_f [N_B];
      int exp_s [N_B];
      exp_f = '{exp_f0, exp_f1, exp_f2, exp_f3};
      exp_s = '{exp_s0, exp_s1, exp_s2, exp_s3};
      key_b = key;
      preload_b_identity();
      ref_ksa_b(key);
      run_b(2 + INIT_B, edges, wrens);
      @(negedge clk);
      start_b = 1'b0;
      checks++;
      if (edges !== N_B * ITER + 1 + INIT_B) begin
         failures++;
         $display("FAIL small_done_edge key=%0d: got %0d expected %0d", key, edges, N_B * ITER + 1 + INIT_B);
      end
      checks++;
      if (wrens !== 2 * N_B + INIT_B) begin
         failures++;
         $display("FAIL small_wren_count key=%0d: got %0d expected %0d", key, wrens, 2 * N_B + INIT_B);
      end
      for (int a = 0; a < N_B; a++) begin
         checks++;
         if (snap_b[a] !== exp_s[a]) begin
            failures++;
            $display("FAIL small_first_swap key=%0d S[%0d]: got %0d expected %0d", key, a, snap_b[a], exp_s[a]);
         end
         checks++;
         if (int'(ram_b[a]) !== exp_f[a] || exp_f[a] !== model_b[a]) begin
            failures++;
            $display("FAIL small_final key=%0d S[%0d]: got %0d expected %0d (model %0d)",
                     key, a, ram_b[a], exp_f[a], model_b[a]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_default_identity();
      int edges, wrens, overlaps, bad;
      logic bf;
      key_a = 24'h000249;
      preload_a(0);
      ref_ksa_a(key_a);
      run_a(0, edges, wrens, overlaps, bf);
      @(negedge clk);
      start_a = 1'b0;
      checks++;
      if (bf !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start: got %b expected 1", bf);
      end
      checks++;
      if (edges !== N_A * ITER + 1 + INIT_A) begin
         failures++;
         $display("FAIL default_done_edge: got %0d expected %0d", edges, N_A * ITER + 1 + INIT_A);
      end
      checks++;
      if (wrens !== 2 * N_A + INIT_A) begin
         failures++;
         $display("FAIL default_wren_count: got %0d expected %0d", wrens, 2 * N_A + INIT_A);
      end
      checks++;
      if (overlaps !== 0) begin
         failures++;
         $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlaps);
      end
      bad = diff_a();
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL default_sbox: got %0d mismatching entries expected 0", bad);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int edges, wrens, overlaps, bad;
      logic bf;
      for (int r = 0; r < 3; r++) begin
         key_a = 24'($urandom());
         preload_a(1);
         ref_ksa_a(key_a);
         run_a(0, edges, wrens, overlaps, bf);
         @(negedge clk);
         start_a = 1'b0;
         bad = diff_a();
         checks++;
         if (bad !== 0 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL random_sbox key=%h: got %0d bad entries done=%b expected 0 and done=1",
                     key_a, bad, done_a);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midrun();
      int edges, wrens, overlaps, bad;
      logic bf;
      key_a = 24'h000249;
      preload_a(0);
      run_a(999, edges, wrens, overlaps, bf);
      reset = 1'b0;                      // sampled at edge 1000
      @(negedge clk);
      checks++;
      if ({busy_a, done_a, wren_a, addr_a, wdata_a} !== 19'd0 || edges !== 999) begin
         failures++;
         $display("FAIL midrun_reset: got busy=%b done=%b wren=%b addr=%h wdata=%h edges=%0d expected zeros at 999",
                  busy_a, done_a, wren_a, addr_a, wdata_a, edges);
      end
      reset = 1'b1;
      start_a = 1'b0;
      @(negedge clk);
      preload_a(0);
      ref_ksa_a(key_a);
      run_a(0, edges, wrens, overlaps, bf);
      @(negedge clk);
      start_a = 1'b0;
      bad = diff_a();
      checks++;
      if (bad !== 0 || edges !== N_A * ITER + 1 + INIT_A) begin
         failures++;
         $display("FAIL restart_after_reset: got %0d bad entries, done edge %0d, expected 0 and %0d",
                  bad, edges, N_A * ITER + 1 + INIT_A);
      end
      @(negedge clk);
   endtask

   task automatic test_start_held();
      int edges, wrens, overlaps, bad, held_bad;
      logic bf;
      key_a = 24'($urandom());
      preload_a(1);
      ref_ksa_a(key_a);
      run_a(0, edges, wrens, overlaps, bf);
      held_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_a !== 1'b1 || busy_a !== 1'b0 || wren_a !== 1'b0) held_bad++;
      end
      bad = diff_a();
      checks++;
      if (held_bad !== 0 || bad !== 0) begin
         failures++;
         $display("FAIL start_held_no_rerun: got %0d bad cycles, %0d bad entries, expected 0 and 0", held_bad, bad);
      end
      start_a = 1'b0;
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL done_release: got done=%b busy=%b expected 0 0", done_a, busy_a);
      end
      if (INIT_A != 0) begin
         for (int a = 0; a < N_A; a++) model_a[a] = a;
      end
      ref_ksa_a(key_a);
      run_a(0, edges, wrens, overlaps, bf);
      @(negedge clk);
      start_a = 1'b0;
      bad = diff_a();
      checks++;
      if (bad !== 0 || edges !== N_A * ITER + 1 + INIT_A || overlaps !== 0) begin
         failures++;
         $display("FAIL second_run: got %0d bad entries, edge %0d, overlaps %0d, expected 0, %0d, 0",
                  bad, edges, overlaps, N_A * ITER + 1 + INIT_A);
      end
      @(negedge clk);
   endtask

`ifdef KSA_INIT_EN
   task automatic test_init_fill();
      int edges, wrens, overlaps, bad;
      logic bf;
      key_a = 24'h000249;
      preload_a(2);
      ref_ksa_a(key_a);
      run_a(0, edges, wrens, overlaps, bf);
      @(negedge clk);
      start_a = 1'b0;
      bad = diff_a();
      checks++;
      if (bad !== 0 || edges !== 2305 + 256) begin
         failures++;
         $display("FAIL init_fill: got %0d bad entries, done edge %0d, expected 0 and %0d", bad, edges, 2305 + 256);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      reset   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      load_a  = 1'b0;
      load_b  = 1'b0;
      key_a   = 24'h0;
      key_b   = 2'b00;
      test_reset();
      test_small(2'b00, 0, 2, 3, 1, 0, 1, 2, 3);
      test_small(2'b01, 0, 2, 3, 1, 1, 0, 2, 3);
      test_default_identity();
      test_random();
      test_reset_midrun();
      test_start_held();
`ifdef KSA_INIT_EN
      test_init_fill();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
